// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the load/store unit.
// One access is in flight at a time; done pulses one cycle after mem_ready or a timeout abort.
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_wr,
  input  logic [DW/8-1:0] ls_mask,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_done,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_err,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_mask,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          if_elig;
  logic          ls_elig;
  logic          grant_if;
  logic          grant_ls;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_MAX) ? v : v + SW'(1);
  endfunction

  // A requester whose done is high this cycle is finishing, not asking again.
  assign if_elig  = if_req & ~if_done;
  assign ls_elig  = ls_req & ~ls_done;
  assign grant_if = if_elig & (~ls_elig | (starve_cnt == STARVE_MAX));
  assign grant_ls = ls_elig & ~grant_if;

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = ls_req & ~ls_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_mask   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      ls_err     <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      ls_err  <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_if) begin
            state      <= GRANT_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_mask   <= '1;
            mem_addr   <= if_addr;
            starve_cnt <= '0;
          end else if (grant_ls) begin
            state     <= GRANT_LS;
            mem_req   <= 1'b1;
            mem_we    <= ls_wr;
            mem_mask  <= ls_wr ? ls_mask : '1;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            if (if_elig) starve_cnt <= sat_inc(starve_cnt);
          end
        end

        GRANT_IF: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if_done <= 1'b1;
            ls_err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        GRANT_LS: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (!mem_we) ls_rdata <= mem_rdata;
            ls_done <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            ls_done <= 1'b1;
            ls_err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level memory image and the arbitration rules.
module tb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int NEVER        = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_wr, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_mask;
  logic        if_done, ls_done, ls_err, stall_if, stall_mem, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  int tests = 0;
  int fails = 0;

  logic [31:0] dev_mem [0:127];
  logic [31:0] ref_mem [0:127];
  int   lat_cfg, cur_lat, resp_cnt, tally;
  bit   monitor_on;
  logic req_rise, won_ls, pend_if, pend_ls;
  logic [31:0] last_ls_rd;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_mask(ls_mask), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0005_1A03);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'({25'd0, a[8:2]});
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory device: answers mem_req after a per-access latency, applying writes to dev_mem.
  task automatic respond();
    if (mem_req) begin
      if (resp_cnt == 0) cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      if (resp_cnt == cur_lat) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          dev_mem[widx(mem_addr)] = merge(dev_mem[widx(mem_addr)], mem_wdata, mem_mask);
          mem_rdata = $urandom;
        end else begin
          mem_rdata = dev_mem[widx(mem_addr)];
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      resp_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      resp_cnt  = 0;
    end
  endtask

  task automatic monitor(input logic e_if, input logic e_ls, input logic was_req);
    logic exp_ls;
    chk("if_done", if_done, pend_if);
    chk("ls_done", ls_done, pend_ls);
    chk("ls_err", ls_err, 1'b0);
    chk("stall_if", stall_if, if_req && !if_done);
    chk("stall_mem", stall_mem, ls_req && !ls_done);
    chk("grant_start", req_rise, !was_req && (e_if || e_ls));
    if (req_rise && (e_if || e_ls)) begin
      exp_ls = e_ls && !(e_if && tally == STARVE_LIMIT);
      chk("grant_who", won_ls, exp_ls);
      if (!exp_ls) tally = 0;
      else if (e_if && tally < STARVE_LIMIT) tally++;
      if (won_ls) begin
        chk("ls_fields_we", mem_we, ls_wr);
        chk("ls_fields_addr", mem_addr, ls_addr);
        chk("ls_fields_mask", mem_mask, ls_wr ? ls_mask : 4'hF);
        if (ls_wr) chk("ls_fields_wdata", mem_wdata, ls_wdata);
      end else begin
        chk("if_fields", {mem_we, mem_mask, mem_addr}, {1'b0, 4'hF, if_addr});
      end
    end
    if (if_done) chk("if_rdata", if_rdata, ref_mem[widx(if_addr)]);
    if (ls_done && !ls_wr) begin
      last_ls_rd = ref_mem[widx(ls_addr)];
      chk("ls_rdata", ls_rdata, last_ls_rd);
    end
    if (ls_done && ls_wr) begin
      chk("ls_rdata_hold", ls_rdata, last_ls_rd);
      ref_mem[widx(ls_addr)] = merge(ref_mem[widx(ls_addr)], ls_wdata, ls_mask);
    end
  endtask

  task automatic cycle();
    logic e_if, e_ls, was_req;
    e_if    = if_req && !if_done;
    e_ls    = ls_req && !ls_done;
    was_req = mem_req;
    @(posedge clk);
    #1;
    req_rise = mem_req && !was_req;
    if (req_rise) won_ls = mem_addr[8];
    if (monitor_on) monitor(e_if, e_ls, was_req);
    respond();
    pend_if = mem_req && mem_ready && !won_ls;
    pend_ls = mem_req && mem_ready && won_ls;
  endtask

  task automatic do_reset();
    if_req = 1'b0;
    ls_req = 1'b0;
    rst    = 1'b1;
    cycle();
    rst    = 1'b0;
  endtask

  task automatic drive_random();
    if (!if_req || if_done) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = 32'($urandom_range(0, 63)) << 2;
    end
    if (!ls_req || ls_done) begin
      ls_req   = ($urandom_range(0, 2) != 0);
      ls_wr    = 1'($urandom);
      ls_mask  = 4'($urandom);
      ls_wdata = $urandom;
      ls_addr  = 32'h100 | (32'($urandom_range(0, 63)) << 2);
    end
  endtask

  initial begin
    logic [31:0] old, exp_w;
    logic [7:0]  seq;
    int          ng, nreq;
    bit          got;

    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; ls_mask = 4'h0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    lat_cfg = 0; cur_lat = 0; resp_cnt = 0; tally = 0; monitor_on = 1'b0;
    req_rise = 1'b0; won_ls = 1'b0; pend_if = 1'b0; pend_ls = 1'b0; last_ls_rd = '0;
    for (int i = 0; i < 128; i++) dev_mem[i] = init_word(i);
    cycle();
    cycle();
    chk("rst_ctrl", {mem_req, mem_we, if_done, ls_done, ls_err}, 5'b0);
    chk("rst_mask", mem_mask, 4'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 64'h0);
    rst = 1'b0;

    // Fetch only, memory answers in the first mem_req cycle.
    dev_mem[16] = 32'h0050_0093;
    if_req = 1'b1; if_addr = 32'h40;
    #1 chk("t1_stall_n", stall_if, 1'b1);
    cycle();
    chk("t1_memreq", {mem_req, mem_we, mem_mask, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h40});
    chk("t1_stall_n1", {stall_if, if_done}, 2'b10);
    cycle();
    chk("t1_done", {if_done, mem_req, stall_if}, 3'b100);
    chk("t1_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    cycle();
    chk("t1_pulse", if_done, 1'b0);

    // Both requesting from reset: ls write first, fetch on the following IDLE.
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h100; ls_mask = 4'b0011; ls_wdata = 32'hA5A5_1234;
    if_req = 1'b1; if_addr = 32'h44;
    cycle();
    chk("t2_ls_grant", {mem_req, mem_we, mem_mask, mem_addr}, {1'b1, 1'b1, 4'b0011, 32'h100});
    chk("t2_wdata", mem_wdata, 32'hA5A5_1234);
    cycle();
    chk("t2_ls_done", {ls_done, if_done, ls_err, mem_req}, 4'b1000);
    chk("t2_ls_rdata_hold", ls_rdata, 32'h0);
    ls_req = 1'b0;
    cycle();
    chk("t2_if_grant", {mem_req, mem_we, mem_mask, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h44});
    cycle();
    chk("t2_if_done", {if_done, if_rdata}, {1'b1, init_word(17)});
    exp_w = init_word(64);
    exp_w[15:0] = 16'h1234;
    chk("t2_mem_write", dev_mem[64], exp_w);
    if_req = 1'b0;

    // Starvation: fetch loses four contests, wins the fifth, then the counter restarts.
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h104; if_req = 1'b1; if_addr = 32'h48;
    seq = '0; ng = 0;
    for (int c = 0; c < 80 && ng < 7; c++) begin
      cycle();
      if (req_rise) begin
        seq[ng] = won_ls;
        ng++;
      end
      if_req = !ls_done;
    end
    chk("t3_grants", ng, 7);
    chk("t3_order", seq[6:0], 7'b1101111);

    // Timeout on an ls read: 16 cycles of mem_req, then done+err together.
    do_reset();
    lat_cfg = 0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h108;
    cycle();
    cycle();
    chk("t4_first_read", {ls_done, ls_rdata}, {1'b1, dev_mem[66]});
    old = dev_mem[66];
    ls_req = 1'b0;
    cycle();
    lat_cfg = NEVER;
    ls_req = 1'b1; ls_addr = 32'h10C;
    nreq = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      cycle();
      if (mem_req) nreq++;
      if (ls_done) got = 1'b1;
    end
    chk("t4_timeout_seen", got, 1'b1);
    chk("t4_err", {ls_done, ls_err, mem_req}, 3'b110);
    chk("t4_req_cycles", nreq, 16);
    chk("t4_rdata_kept", ls_rdata, old);
    ls_req = 1'b0;
    cycle();
    chk("t4_pulse", {ls_done, ls_err}, 2'b00);
    lat_cfg = 0;
    if_req = 1'b1; if_addr = 32'h4C;
    cycle();
    chk("t4_idle_grant", {mem_req, mem_addr}, {1'b1, 32'h4C});
    cycle();
    chk("t4_if_done", {if_done, ls_err, if_rdata}, {2'b10, init_word(19)});
    old = if_rdata;
    // Fetch timeout also flags ls_err, alongside if_done.
    lat_cfg = NEVER;
    if_addr = 32'h50;
    cycle();
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      cycle();
      if (if_done) got = 1'b1;
    end
    chk("t4_if_timeout", {got, if_done, ls_err}, 3'b111);
    chk("t4_if_rdata_kept", if_rdata, old);
    if_req = 1'b0;

    // Reset mid-access: transaction is dropped without a done pulse.
    do_reset();
    lat_cfg = NEVER;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h110;
    cycle();
    chk("t5_req", mem_req, 1'b1);
    cycle();
    chk("t5_req_held", mem_req, 1'b1);
    rst = 1'b1; ls_req = 1'b0;
    cycle();
    chk("t5_rst", {mem_req, ls_done, ls_err}, 3'b000);
    rst = 1'b0;
    cycle();
    chk("t5_no_done", {mem_req, ls_done}, 2'b00);
    lat_cfg = 0;
    if_req = 1'b1; if_addr = 32'h54;
    cycle();
    chk("t5_if_grant", {mem_req, mem_addr}, {1'b1, 32'h54});
    cycle();
    chk("t5_if_done", {if_done, if_rdata}, {1'b1, init_word(21)});
    if_req = 1'b0;

    // Randomized traffic with random memory latency.
    do_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = dev_mem[i];
    lat_cfg = -1; tally = 0; last_ls_rd = '0;
    cycle();
    monitor_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      drive_random();
      cycle();
    end
    if_req = 1'b0; ls_req = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    monitor_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
